// File: rtl/seq_gen_top.sv
// Serial pattern transmitter: latches a parallel pattern and shifts it out MSB-first,
// one bit per rising edge of the debounced `next` button level.
module seq_gen_top #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    output logic             out_bit,
    output logic             valid,
    output logic             done,
    output logic             busy,
    output logic [LEN_W-1:0] bits_left,
    output logic [1:0]       state_display
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             next_last;
    logic             step;
    logic [LEN_W-1:0] load_len;

    // Handshake: while valid=1, out_bit holds the current pattern bit; each rising edge
    // of next (step) consumes that bit, and the following bit appears one cycle later.
    assign step          = next & ~next_last;
    assign load_len      = (length > WIDTH_L) ? WIDTH_L : length;
    assign state_display = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bits_left <= '0;
            next_last <= 1'b0;
            out_bit   <= 1'b0;
            valid     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            next_last <= next;
            case (state)
                IDLE: begin
                    if (start && (length != '0)) begin
                        state     <= SEND;
                        shreg     <= pattern;
                        bits_left <= load_len;
                        out_bit   <= pattern[WIDTH-1];
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (step) begin
                        if (bits_left > LEN_W'(1)) begin
                            shreg     <= {shreg[WIDTH-2:0], 1'b0};
                            bits_left <= bits_left - LEN_W'(1);
                            out_bit   <= shreg[WIDTH-2];
                        end else begin
                            // Last bit consumed: announce completion for one cycle.
                            state     <= DONE;
                            bits_left <= '0;
                            out_bit   <= 1'b0;
                            valid     <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    out_bit <= 1'b0;
                    valid   <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_top.sv
// Bench for seq_gen_top: directed scenarios plus random traffic against a queue-based
// reference model, and a loopback into a behavioural "010" sequence detector.
module tb_seq_gen_top;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             next = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [LEN_W-1:0] length = '0;
    logic             out_bit, valid, done, busy;
    logic [LEN_W-1:0] bits_left;
    logic [1:0]       state_display;

    int n_cmp = 0;
    int n_err = 0;

    seq_gen_top #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .next(next), .start(start),
        .pattern(pattern), .length(length), .out_bit(out_bit), .valid(valid),
        .done(done), .busy(busy), .bits_left(bits_left), .state_display(state_display)
    );

    always #5 clk = ~clk;

    // Reference model: remaining bits kept in a queue; phase 0=idle, 1=sending, 2=done.
    logic exp_q[$];
    int   m_phase = 0;
    logic m_prev = 1'b0;

    always @(posedge clk) begin
        logic st;
        int   n;
        if (reset) begin
            m_phase = 0;
            exp_q.delete();
            m_prev = 1'b0;
        end else begin
            st = next && !m_prev;
            m_prev = next;
            case (m_phase)
                0: if (start && length != 0) begin
                    n = (int'(length) > WIDTH) ? WIDTH : int'(length);
                    exp_q.delete();
                    for (int i = 0; i < n; i++) exp_q.push_back(pattern[WIDTH-1-i]);
                    m_phase = 1;
                end
                1: if (st) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Behavioural detector for the sequence 0,1,0 (overlapping), stepped by the same button.
    int   det_state = 0;
    logic det_prev = 1'b0;
    logic det_out;
    logic [2:0] det_hist = '0;
    int   det_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            det_state = 0;
            det_prev = 1'b0;
            det_hist = '0;
            det_cnt = 0;
        end else begin
            if (next && !det_prev) begin
                det_hist = {det_hist[1:0], out_bit};
                det_cnt = det_cnt + 1;
                if (det_cnt >= 3 && det_hist == 3'b010) det_state = 3;
                else if (det_hist[1:0] == 2'b01) det_state = 2;
                else if (det_hist[0] == 1'b0) det_state = 1;
                else det_state = 0;
            end
            det_prev = next;
        end
    end
    assign det_out = (det_state == 3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        logic eb;
        eb = (m_phase == 1 && exp_q.size() > 0) ? exp_q[0] : 1'b0;
        chk("out_bit", 32'(out_bit), 32'(eb));
        chk("valid", 32'(valid), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("bits_left", 32'(bits_left), 32'(exp_q.size()));
        chk("state_display", 32'(state_display), 32'(m_phase));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic press(input int hi, input int lo);
        next = 1'b1;
        cycles(hi);
        next = 1'b0;
        cycles(lo);
    endtask

    task automatic load(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l);
        pattern = p;
        length = l;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_bits;
        int done_cnt;

        // Reset values
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            chk("rst_state", 32'(state_display), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end

        // Basic send: 1010 with bits_left 4,3,2,1
        exp_bits = 4'b1010;
        load(8'b1010_0000, 4'd4);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            chk("basic_bit", 32'(out_bit), 32'(exp_bits[3-i]));
            chk("basic_left", 32'(bits_left), 32'(4 - i));
            next = 1'b1;
            for (int c = 0; c < 3; c++) begin cycles(1); if (done) done_cnt++; end
            next = 1'b0;
            for (int c = 0; c < 3; c++) begin cycles(1); if (done) done_cnt++; end
        end
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_idle", 32'(state_display), 32'd0);

        // Held next gives a single step
        load(8'b1100_0000, 4'd3);
        next = 1'b1;
        cycles(10);
        next = 1'b0;
        cycles(2);
        chk("held_left", 32'(bits_left), 32'd2);
        press(1, 1);
        press(1, 3);
        chk("held_idle", 32'(state_display), 32'd0);

        // next already high at load: no step until re-pressed
        next = 1'b1;
        cycles(2);
        load(8'b1000_0000, 4'd2);
        cycles(4);
        chk("prehigh_left", 32'(bits_left), 32'd2);
        chk("prehigh_bit", 32'(out_bit), 32'd1);
        next = 1'b0;
        cycles(2);
        chk("prehigh_left2", 32'(bits_left), 32'd2);
        press(2, 2);
        chk("prehigh_left3", 32'(bits_left), 32'd1);
        press(2, 4);

        // Length bounds
        pattern = 8'hFF;
        length = 4'd0;
        start = 1'b1;
        cycles(3);
        start = 1'b0;
        chk("len0_valid", 32'(valid), 32'd0);
        chk("len0_state", 32'(state_display), 32'd0);
        load(8'hFF, 4'd12);
        chk("len12_left", 32'(bits_left), 32'd8);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            chk("len12_no_done", 32'(done), 32'd0);
            press(1, 1);
        end
        chk("len12_idle", 32'(state_display), 32'd0);

        // Reset after 2 of 5 steps
        load(8'b1011_0000, 4'd5);
        press(2, 2);
        press(2, 2);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("midrst_state", 32'(state_display), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_left", 32'(bits_left), 32'd0);
        cycles(2);
        load(8'b1011_0000, 4'd5);
        chk("midrst_msb", 32'(out_bit), 32'd1);
        chk("midrst_full", 32'(bits_left), 32'd5);
        for (int i = 0; i < 5; i++) press(1, 2);
        cycles(2);

        // Loopback into the detector
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        load(8'b0100_0000, 4'd3);
        press(2, 2);
        press(2, 2);
        chk("loop_det_pre", 32'(det_out), 32'd0);
        next = 1'b1;
        cycles(1);
        chk("loop_done", 32'(done), 32'd1);
        chk("loop_det_state", 32'(det_state), 32'd3);
        chk("loop_det_out", 32'(det_out), 32'd1);
        next = 1'b0;
        cycles(3);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) next = ~next;
            start = ($urandom_range(0, 4) == 0);
            pattern = WIDTH'($urandom);
            length = LEN_W'($urandom_range(0, 11));
            reset = ($urandom_range(0, 99) == 0);
            cycles(1);
        end
        reset = 1'b0;
        start = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_gen_top.md
# seq_gen_top

Serial pattern transmitter that drives the `in` bit of the team's button-stepped sequence detector. It latches a parallel pattern and presents it MSB-first on `out_bit`. It advances one bit per rising edge of the `next` step input, using the same edge rule as the detector, so both blocks step on the same clock edge. Sits in the board top-level between the switch/button inputs and the detector, and in loopback benches.

## Interface

**Parameters**
- `WIDTH`, 8: pattern width in bits.
- `LEN_W`, 4: width of `length` and `bits_left`; must hold the value `WIDTH`.

**Ports**
- `clk`, in, 1: system clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `next`, in, 1: step input, a debounced button level; only its rising edge advances.
- `start`, in, 1: level; sampled only in IDLE; requests a load.
- `pattern`, in, `WIDTH`: bits to send; `pattern[WIDTH-1]` is sent first.
- `length`, in, `LEN_W`: number of bits to send.
- `out_bit`, out, 1: current bit; feeds the detector's `in`.
- `valid`, out, 1: high while `out_bit` carries a pattern bit (SEND state).
- `done`, out, 1: one-cycle pulse after the last bit is consumed.
- `busy`, out, 1: high in SEND or DONE.
- `bits_left`, out, `LEN_W`: bits still to be consumed, including the current one.
- `state_display`, out, 2: IDLE=0, SEND=1, DONE=2.

## Operation

**Edge detection**
- Register `next_last <= next` every cycle in all states; reset value 0.
- `step = next & ~next_last`.

**Internal state:** shift register `shreg[WIDTH-1:0]`, counter `bits_left`, 2-bit state register.

**IDLE**
- `out_bit`=0, `valid`=0, `busy`=0, `done`=0.
- If `start`=1 and `length`≠0: load `shreg`=`pattern`, `bits_left`=min(`length`, `WIDTH`), go to SEND.
- If `length`=0: `start` is ignored and the block stays in IDLE.
- `step` in IDLE has no effect, including in the same cycle as `start`.

**SEND**
- `out_bit`=`shreg[WIDTH-1]`, `valid`=1, `busy`=1.
- On `step` with `bits_left`>1: shift `shreg` left by 1 with 0 fill, decrement `bits_left`.
- On `step` with `bits_left`=1: `bits_left`=0, go to DONE.
- `start` is ignored. Changes to `pattern` or `length` have no effect after the load.

**DONE**
- Lasts exactly one cycle, then IDLE.
- `done`=1, `busy`=1, `valid`=0, `out_bit`=0.
- `start` and `step` are ignored.

**Other rules**
- Unused state encoding 3: next state is IDLE.
- All outputs are decoded from registers; there is no combinational path from inputs to outputs.

## Timing

- **Reset:** state=IDLE, `shreg`=0, `bits_left`=0, `next_last`=0. Outputs all 0: `out_bit`, `valid`, `done`, `busy`, `bits_left`, `state_display`.
- **Reset mid-SEND or mid-DONE:** same values on the next cycle. No `done` pulse is produced.
- **Load latency:** `start` sampled high at edge k means `valid`=1 with the first bit on `out_bit` from cycle k+1.
- **Step latency:** detector and generator see `step` in the same cycle k.
  - The detector consumes the current `out_bit` at edge k.
  - The generator presents the next bit from cycle k+1.
- **Held `next`:** one step per low→high transition. `next` held high for N cycles yields one step.
- **`next` already high on entry to SEND:** produces no step until it goes low and then high again.
- **Last bit:** `step` with `bits_left`=1 at edge k gives `done`=1 in cycle k+1 and IDLE in cycle k+2.
- **Earliest restart:** a new `start` is accepted at edge k+2.
- **Minimum transmission:** length L takes 1 load cycle, then L steps, then 1 DONE cycle.

## Test plan

1. **Reset values:** apply `reset` for 2 cycles, then release with all inputs 0 → every output is 0 and `state_display`=0 for 5 cycles.
2. **Basic send:** `pattern`=8'b1010_0000, `length`=4, pulse `start`; then 4 `next` pulses, each high 3 cycles and low 3 cycles.
   - Before each successive step, `out_bit` reads 1,0,1,0 and `bits_left` reads 4,3,2,1.
   - `done` pulses for exactly one cycle after the 4th rising edge; then `state_display`=0.
3. **Edge discipline:**
   - Hold `next`=1 for 10 cycles during SEND → exactly one step.
   - `next` already high when `start` loads → no step until `next` is released and pressed again.
4. **Length bounds:**
   - `length`=0 with `start`=1 → stays IDLE, `valid`=0.
   - `length`=12, `pattern`=8'hFF → `bits_left`=8; exactly 8 steps precede `done`.
5. **Reset mid-operation:** assert `reset` after 2 of 5 steps → next cycle is IDLE, all outputs 0, no `done`. A following `start` sends the full pattern from the MSB.
6. **Loopback:** `out_bit` drives the detector's `in`; shared `next`; `pattern`=8'b0100_0000, `length`=3.
   - After 3 steps, the detector's state is 3 and its `out`=1.
   - Generator `done` pulses in the same cycle that the detector's `out` first rises.
